fifo_write_arbiter: RTL and testbench

- Shares the async_fifo write port among NUM_REQ requesters in the write_clk domain.
- Round-robin arbitration with bounded bursts: a granted requester may push up to MAX_BURST beats before the grant rotates.
- Each FIFO entry is tagged with the source ID, so the read side can demultiplex.
- Drives p_write_en/p_write_data and consumes p_write_full directly. clk is the FIFO's write_clk.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 88 ++++++++
 tb/tb_fifo_write_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_BITS = 30;
    localparam int DEF_MAX_BURST = 4;

    // Source-tag width; a single requester still needs one tag bit.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake plus FIFO write-port signals shared by the arbiter.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ID_BITS   = id_bits(NUM_REQ),
    parameter int BITS      = ID_BITS + DATA_BITS
);
    logic [NUM_REQ-1:0]           p_req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] p_req_data;
    logic [NUM_REQ-1:0]           p_req_ready;
    logic                         p_write_en;
    logic [BITS-1:0]              p_write_data;
    logic                         p_write_full;

    modport slave (
        input  p_req_valid, p_req_data, p_write_full,
        output p_req_ready, p_write_en, p_write_data
    );

    modport master (
        output p_req_valid, p_req_data, p_write_full,
        input  p_req_ready, p_write_en, p_write_data
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [ID_BITS-1:0] idx,
    output logic               any
);
    logic [ID_BITS-1:0] j;

    // Scan from the far end so the candidate nearest ptr overwrites the rest.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ID_BITS'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port; entries tagged with source ID.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_BITS   = id_bits(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   p_grant,
    output logic                 p_busy,
    output logic [31:0]          p_beat_count
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t               state, state_n;
    logic [ID_BITS-1:0]   rr_ptr, gidx, pick_idx;
    logic [CNT_W-1:0]     burst_cnt;
    logic                 pick_any, fire, leave, last_beat;
    logic [DATA_BITS-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.p_req_data[i*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) u_pick (
        .req (bus.p_req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign last_beat = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign p_busy    = (state == BURST);

    // rst gates the strobe so an in-flight burst cycle never writes.
    always_comb begin
        state_n          = state;
        fire             = 1'b0;
        leave            = 1'b0;
        bus.p_req_ready  = '0;
        bus.p_write_en   = 1'b0;
        bus.p_write_data = '0;
        case (state)
            IDLE: if (pick_any) state_n = BURST;
            BURST: begin
                fire  = bus.p_req_valid[gidx] && !bus.p_write_full && !rst;
                leave = !bus.p_req_valid[gidx] || (fire && last_beat);
                if (leave) state_n = IDLE;
                bus.p_write_data = {gidx, slice[gidx]};
                if (fire) begin
                    bus.p_req_ready = NUM_REQ'(1) << gidx;
                    bus.p_write_en  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gidx         <= '0;
            burst_cnt    <= '0;
            p_grant      <= '0;
            p_beat_count <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && pick_any) begin
                gidx      <= pick_idx;
                p_grant   <= NUM_REQ'(1) << pick_idx;
                burst_cnt <= '0;
            end
            if (fire) begin
                burst_cnt <= burst_cnt + 1'b1;
                if (p_beat_count != '1) p_beat_count <= p_beat_count + 1'b1;
            end
            if (state == BURST && leave) begin
                rr_ptr  <= (gidx == ID_BITS'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                p_grant <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios plus randomized traffic against a grant/beat reference model.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N   = 4;
    localparam int DB  = 30;
    localparam int MB  = 4;
    localparam int IDB = 2;
    localparam int B   = IDB + DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  grant;
    logic          busy;
    logic [31:0]   beats;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DB)) bus ();

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .p_grant      (grant),
        .p_busy       (busy),
        .p_beat_count (beats)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            fails  = 0;
    logic [DB-1:0] dat [N];
    bit            rand_mode = 1'b0;

    // Reference model: who owns the port, beats in this grant, where the next scan starts.
    int            owner  = -1;
    int            nbeats = 0;
    int            start  = 0;
    logic [31:0]   total  = '0;

    logic [B-1:0]  got [$];
    logic [N-1:0]  last_grant;
    logic          last_en;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic full, input logic r);
        logic fire;
        logic found;
        @(negedge clk);
        rst              = r;
        bus.p_req_valid  = v;
        bus.p_write_full = full;
        for (int i = 0; i < N; i++) bus.p_req_data[i*DB +: DB] = dat[i];
        #1;
        fire = (owner >= 0) && !r && v[owner] && !full;
        chk("write_en", 64'(bus.p_write_en), 64'(fire));
        chk("req_ready", 64'(bus.p_req_ready), fire ? 64'(N'(1) << owner) : 64'd0);
        chk("grant", 64'(grant), (owner >= 0) ? 64'(N'(1) << owner) : 64'd0);
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("beat_count", 64'(beats), 64'(total));
        if (fire)           chk("write_data", 64'(bus.p_write_data), 64'({IDB'(owner), dat[owner]}));
        else if (owner < 0) chk("idle_data", 64'(bus.p_write_data), 64'd0);
        if (bus.p_write_en) got.push_back(bus.p_write_data);
        last_grant = grant;
        last_en    = bus.p_write_en;

        if (r) begin
            owner = -1; nbeats = 0; start = 0; total = '0;
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(start + k) % N]) begin
                    owner  = (start + k) % N;
                    nbeats = 0;
                    found  = 1'b1;
                end
            end
        end else begin
            if (fire) begin
                nbeats++;
                if (total != 32'hFFFF_FFFF) total++;
                dat[owner] = rand_mode ? DB'($urandom) : dat[owner] + 1'b1;
            end
            if (!v[owner] || (fire && nbeats == MB)) begin
                start = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic do_reset();
        repeat (3) cycle('1, 1'b0, 1'b1);
        got.delete();
    endtask

    initial begin
        bus.p_req_valid  = '0;
        bus.p_req_data   = '0;
        bus.p_write_full = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = DB'(i * 32'h100);

        // Reset held with all valid, then first arbitration.
        do_reset();
        cycle(4'b1111, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0);
        chk("post_reset_grant", 64'(last_grant), 64'(4'b0001));

        // Single requester: two bursts of four with a one-cycle gap.
        do_reset();
        dat[1] = DB'(32'h10);
        repeat (10) cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        chk("single_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < got.size(); k++)
            chk("single_data", 64'(got[k]), 64'(32'h4000_0010 + k));
        chk("single_beats", 64'(beats), 64'd8);

        // Round robin with everyone valid: order 0,1,2,3,0, four beats each.
        do_reset();
        repeat (25) cycle(4'b1111, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        chk("rr_count", 64'(got.size()), 64'd20);
        for (int k = 0; k < got.size(); k++)
            chk("rr_tag", 64'(got[k][B-1 -: IDB]), 64'((k / 4) % 4));

        // Full backpressure inside requester 2's burst.
        do_reset();
        dat[2] = DB'(32'h200);
        repeat (3) cycle(4'b0100, 1'b0, 1'b0);
        repeat (5) begin
            cycle(4'b0100, 1'b1, 1'b0);
            chk("bp_grant", 64'(last_grant), 64'(4'b0100));
            chk("bp_no_write", 64'(last_en), 64'd0);
        end
        repeat (2) cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < got.size(); k++)
            chk("bp_data", 64'(got[k]), 64'(32'h8000_0200 + k));

        // Early drop by requester 3 wraps the pointer to 0.
        do_reset();
        repeat (3) cycle(4'b1000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        chk("drop_count", 64'(got.size()), 64'd2);
        repeat (2) cycle(4'b1010, 1'b0, 1'b0);
        chk("drop_next_grant", 64'(last_grant), 64'(4'b0010));
        cycle(4'b0000, 1'b0, 1'b0);

        // Reset in the middle of a burst.
        do_reset();
        repeat (2) cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b1);
        chk("midrst_no_write", 64'(last_en), 64'd0);
        chk("midrst_count", 64'(got.size()), 64'd1);
        repeat (2) cycle(4'b0101, 1'b0, 1'b0);
        chk("midrst_grant", 64'(last_grant), 64'(4'b0001));
        cycle(4'b0000, 1'b0, 1'b0);

        // Randomized traffic, backpressure and occasional reset.
        rand_mode = 1'b1;
        repeat (3000) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < 75);
            cycle(v, $urandom_range(0, 99) < 15, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
